ttt_token_ingress: RTL and testbench

//  Input stage that sits directly upstream of the tick-tock-tokens neuron core.
//  Off-chip hosts deliver token events as a strobe pin plus data pins (neuron id,

---
 rtl/ttt_pkg.sv | 19 +
 rtl/ttt_token_ingress_if.sv | 30 +++
 rtl/ttt_sync.sv | 28 ++
 rtl/ttt_token_ingress.sv | 110 +++++++++++
 tb/tb_ttt_token_ingress.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tick-tock-tokens datapath.
//   ID_W_DEF : default neuron id width
//   pol_e    : token polarity (POL_EXC = excitatory, POL_INH = inhibitory)
//   token_t  : {id, pol} token as consumed by the neuron core
package ttt_pkg;

  localparam int unsigned ID_W_DEF = 4;

  typedef enum logic {
    POL_INH = 1'b0,
    POL_EXC = 1'b1
  } pol_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    pol_e                pol;
  } token_t;

endpackage

// File: rtl/ttt_token_ingress_if.sv
// Token handshake between the ingress stage and the neuron core.
//   out_valid : head token available (producer -> consumer)
//   out_ready : consumer takes the head this cycle (consumer -> producer)
//   out_id    : head neuron id
//   out_pol   : head polarity
// master = ingress side, slave = core side.
interface ttt_token_ingress_if #(
  parameter int unsigned ID_W = ttt_pkg::ID_W_DEF
) ();

  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic            out_pol;

  modport master (
    output out_valid,
    output out_id,
    output out_pol,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    input  out_pol,
    output out_ready
  );

endinterface

// File: rtl/ttt_sync.sv
// N-stage flip-flop synchroniser for an asynchronous pin vector.
//   clk, rst_n : clock, async active-low reset (chain clears to 0)
//   d          : asynchronous input vector
//   q          : synchronised output, STAGES cycles behind d
module ttt_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ttt_token_ingress.sv
// Pin-level token ingress for the neuron core.
// Synchronises strobe/id/pol pins, turns each rising strobe edge into a
// token pushed into a small FIFO, presents the head over a valid/ready
// handshake and records events lost to overflow.
//   clk, rst_n   : clock, async active-low reset
//   ena          : 0 = ignore strobe edges
//   strobe_in    : async event strobe (event = rising edge)
//   id_in        : async neuron id
//   pol_in       : async polarity
//   clr_flags    : sync pulse clearing overflow and drop_count
//   tok          : master side of the token handshake
//   fill         : entries queued
//   overflow     : sticky, an event was dropped
//   drop_count   : dropped events, saturating
module ttt_token_ingress
  import ttt_pkg::*;
#(
  parameter int unsigned ID_W        = ID_W_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DROP_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       strobe_in,
  input  logic [ID_W-1:0]            id_in,
  input  logic                       pol_in,
  input  logic                       clr_flags,
  ttt_token_ingress_if.master        tok,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic            strobe_s;
  logic [ID_W-1:0] id_s;
  logic            pol_s;
  logic            prev_strobe;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [ID_W:0]   mem [DEPTH];
  logic [ID_W:0]   head;

  logic push, pop, empty, full, wr_en, drop;

  // Identical chains keep data aligned with the strobe edge.
  ttt_sync #(.WIDTH(1),    .STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk(clk), .rst_n(rst_n), .d(strobe_in), .q(strobe_s));
  ttt_sync #(.WIDTH(ID_W), .STAGES(SYNC_STAGES)) u_sync_id (
    .clk(clk), .rst_n(rst_n), .d(id_in),     .q(id_s));
  ttt_sync #(.WIDTH(1),    .STAGES(SYNC_STAGES)) u_sync_pol (
    .clk(clk), .rst_n(rst_n), .d(pol_in),    .q(pol_s));

  // Edge register tracks the strobe regardless of ena, so enabling while the
  // strobe is already high does not fabricate an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_strobe <= 1'b0;
    else        prev_strobe <= strobe_s;
  end

  assign push  = strobe_s & ~prev_strobe & ena;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign pop   = tok.out_valid & tok.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {id_s, pol_s};
  end

  // A drop in the same cycle as clr_flags leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_flags)               drop_count <= DROP_W'(1);
      else if (drop_count != '1)   drop_count <= drop_count + 1'b1;
    end else if (clr_flags) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign fill          = wr_ptr - rd_ptr;
  assign tok.out_valid = ~empty;
  assign tok.out_id    = empty ? '0 : head[ID_W:1];
  assign tok.out_pol   = empty ? POL_INH : head[0];

endmodule

// File: tb/tb_ttt_token_ingress.sv
module tb_ttt_token_ingress;
  import ttt_pkg::*;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       strobe_in = 1'b0;
  logic [3:0] id_in = '0;
  logic       pol_in = 1'b0;
  logic       clr_flags = 1'b0;
  logic [2:0] fill;
  logic       overflow;
  logic [3:0] drop_count;

  ttt_token_ingress_if #(.ID_W(ID_W)) tok ();

  ttt_token_ingress #(
    .ID_W(ID_W), .DEPTH(DEPTH), .SYNC_STAGES(2), .DROP_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .strobe_in(strobe_in),
    .id_in(id_in), .pol_in(pol_in), .clr_flags(clr_flags), .tok(tok),
    .fill(fill), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] id;
    logic       pol;
  } exp_t;

  exp_t sb[$];
  int   m_drops = 0;
  logic m_ovf = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_fill"}, 32'(fill), 32'(sb.size()));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_drops"}, 32'(drop_count), 32'(m_drops));
  endtask

  // One strobe event with ena=1; optional pop and/or clr_flags aligned with
  // the cycle in which the push lands (between edges 2 and 3 after the rise).
  task automatic send(input logic [3:0] id, input logic pol,
                      input bit pop_at, input bit clr_at);
    bit dropped;
    id_in = id;
    pol_in = pol;
    tick();
    strobe_in = 1'b1;
    tick();
    tick();
    if (pop_at) begin
      check("pop_head_id", 32'(tok.out_id), 32'(sb[0].id));
      tok.out_ready = 1'b1;
    end
    if (clr_at) clr_flags = 1'b1;
    tick();
    tok.out_ready = 1'b0;
    clr_flags = 1'b0;
    if (pop_at) void'(sb.pop_front());
    dropped = (sb.size() >= DEPTH);
    if (!dropped) begin
      sb.push_back('{id: id, pol: pol});
      if (clr_at) begin
        m_ovf = 1'b0;
        m_drops = 0;
      end
    end else begin
      m_ovf = 1'b1;
      m_drops = clr_at ? 1 : ((m_drops == 15) ? 15 : m_drops + 1);
    end
    strobe_in = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic drain();
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 32'(tok.out_valid), 32'd1);
      check("drain_id", 32'(tok.out_id), 32'(sb[0].id));
      check("drain_pol", 32'(tok.out_pol), 32'(sb[0].pol));
      tok.out_ready = 1'b1;
      tick();
      tok.out_ready = 1'b0;
      void'(sb.pop_front());
      check("drain_fill", 32'(fill), 32'(sb.size()));
    end
    check("empty_valid", 32'(tok.out_valid), 32'd0);
    check("empty_id", 32'(tok.out_id), 32'd0);
    check("empty_pol", 32'(tok.out_pol), 32'd0);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovf = 1'b0;
    m_drops = 0;
  endtask

  initial begin
    tok.out_ready = 1'b0;

    // 1: reset with pins toggling
    for (int i = 0; i < 4; i++) begin
      strobe_in = $urandom_range(0, 1);
      id_in = 4'($urandom_range(0, 15));
      pol_in = $urandom_range(0, 1);
      tok.out_ready = $urandom_range(0, 1);
      tick();
      check("rst_valid", 32'(tok.out_valid), 32'd0);
      check("rst_id", 32'(tok.out_id), 32'd0);
      check("rst_pol", 32'(tok.out_pol), 32'd0);
      check_flags("rst");
    end
    strobe_in = 1'b0;
    id_in = '0;
    pol_in = 1'b0;
    tok.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(tok.out_valid), 32'd0);
    check_flags("post_rst");
    ena = 1'b1;

    // 2: single event latency
    id_in = 4'h9;
    pol_in = 1'b1;
    tick();
    strobe_in = 1'b1;
    tick();
    tick();
    check("lat_valid_edge2", 32'(tok.out_valid), 32'd0);
    tick();
    check("lat_valid_edge3", 32'(tok.out_valid), 32'd1);
    check("lat_id", 32'(tok.out_id), 32'h9);
    check("lat_pol", 32'(tok.out_pol), 32'd1);
    sb.push_back('{id: 4'h9, pol: 1'b1});
    strobe_in = 1'b0;
    tick();
    tick();
    tick();
    drain();
    check_flags("single");

    // 3: overflow
    for (int i = 1; i <= 6; i++) send(4'(i), 1'(i % 2), 1'b0, 1'b0);
    check_flags("ovf");
    check("ovf_head", 32'(tok.out_id), 32'd1);
    drain();
    clear_flags();
    check_flags("ovf_clr");

    // 4: full plus simultaneous pop
    for (int i = 0; i < 4; i++) send(4'hA + 4'(i), 1'b1, 1'b0, 1'b0);
    send(4'hE, 1'b0, 1'b1, 1'b0);
    check_flags("full_pop");
    drain();

    // 5: ena gating
    ena = 1'b0;
    id_in = 4'h7;
    tick();
    strobe_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("ena0_fill", 32'(fill), 32'd0);
    ena = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("ena_rise_fill", 32'(fill), 32'd0);
    check("ena_rise_valid", 32'(tok.out_valid), 32'd0);
    strobe_in = 1'b0;
    tick();
    tick();
    tick();
    send(4'h8, 1'b1, 1'b0, 1'b0);
    check_flags("ena_edge");
    drain();

    // 6: saturation and clear
    for (int i = 0; i < 4; i++) send(4'(i + 3), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send(4'hF, 1'b1, 1'b0, 1'b0);
    check_flags("sat");
    clear_flags();
    check_flags("clr_alone");
    send(4'h1, 1'b1, 1'b0, 1'b1);
    check_flags("clr_with_drop");

    // 7: reset mid-operation
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    check("midrst_valid", 32'(tok.out_valid), 32'd0);
    check_flags("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_flags("midrst_rel");
    send(4'h5, 1'b0, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
